reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Producer-side hazard tracking for the 5-stage ARM pipeline.
- Records each issued instruction's destination as it moves through the EXE and MEM shadow slots, and keeps a per-register pending-write count.
- Generates the ID-stage stall from that tracked state, in both forwarding and non-forwarding modes.
- Sits beside the ID/EXE boundary and replaces the ad-hoc passing of Dest_Ex/Dest_Mem from the pipeline registers.

Parameters:
- NREGS, 16, number of architectural registers (index width = clog2(NREGS) = 4).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- issue_valid  input  1  ID presents an instruction this cycle.
- issue_wb_en  input  1  issued instruction writes back.
- issue_mem_read  input  1  issued instruction is a load.
- issue_dest  input  4  destination register of issued instruction.
- src1  input  4  Rn of the instruction in ID.
- src2  input  4  Rm/Rd of the instruction in ID.
- two_src  input  1  src2 is a real operand.
- forward_en  input  1  1 = forwarding datapath enabled.
- freeze  input  1  memory wait; holds all state.
- flush  input  1  taken branch; the ID instruction is not issued.
- hazard  output  1  stall ID/IF this cycle.
- exe_dest, mem_dest  output  4 each  shadow-slot destinations, for the forwarding unit.
- exe_wb_en, mem_wb_en  output  1 each  shadow-slot write enables (already qualified by slot valid).
- exe_mem_read  output  1  EXE slot holds a load.
- busy_mask  output  NREGS  bit i = pending-write count of register i is nonzero.
- stall_count  output  CNT_W  cycles in which hazard=1 and freeze=0; saturates at all-ones.

Behaviour:
- **Reset:** when rst=0 at a clock edge:
  - both slots become invalid bubbles (dest=0, wb_en=0, mem_read=0);
  - all busy counts = 0 and stall_count = 0;
  - consequently hazard=0 and every output reads 0.
  - Reset overrides freeze and flush.
- **Slots:** each of EXE and MEM holds {valid, wb_en, mem_read, dest}. Unqualified outputs are taken directly from slot registers.
- **Per-register busy count:** 2-bit count per register, range 0..2.
- **Advance:** on a clock edge with rst=1 and freeze=0:
  - MEM <= EXE;
  - EXE <= issued entry if accept, else bubble, where accept = issue_valid & ~hazard & ~flush.
- **Count update (same edge):**
  - inc = accept & issue_wb_en, on issue_dest;
  - dec = MEM.valid & MEM.wb_en, on MEM.dest;
  - inc and dec on the same register leave its count unchanged;
  - on different registers, each is applied independently.
- **Freeze=1:** slots, counts and stall_count hold. hazard is still evaluated combinationally from the held state.
- **Hazard, forward_en=0** (combinational from current state):
  - hazard = busy[src1] != 0, OR (two_src & busy[src2] != 0).
  - This is equivalent to matching the EXE or MEM dest with wb_en set.
- **Hazard, forward_en=1:**
  - hazard = EXE.valid & EXE.mem_read & EXE.wb_en & (src1 == EXE.dest, OR two_src & src2 == EXE.dest).
  - Load-use only: exactly one bubble is inserted, after which the load has moved to MEM.
- **issue_valid:** hazard is also forced to 0 when issue_valid=0, since there is no consumer.
- **Flush:** a flushed ID instruction is not accepted. Instructions already in EXE/MEM complete normally.
- **Counter guards:** a busy count of 3 is illegal.
  - Increment saturates at 2; an assertion fires if this is attempted.
  - Decrement from 0 is impossible by construction; an assertion fires if it occurs.
- **stall_count:** increments when hazard=1 and freeze=0; holds at 2^CNT_W-1.
- **Invariant:** busy[i] equals the number of valid slots with wb_en=1 and dest=i. The bench checks this every cycle.

Decomposition:
- **Shared package (pipeline_pkg):**
  - REG_IDX_W = 4 and NREGS = 16;
  - the slot struct typedef {valid, wb_en, mem_read, dest};
  - the BUBBLE constant.
- **Sub-module reg_busy_counter:** one instance per register, generated NREGS times.
  - Ports: clk, rst, inc, dec, busy.
  - Contains the 2-bit saturating up/down counter.

Test Plan:
- **Reset mid-operation:** reset with 2 pending writes (r3 in EXE, r5 in MEM), rst=0 for 1 cycle -> busy_mask=0, all slots bubbles, hazard=0, stall_count=0.
- **Non-forwarding RAW:** forward_en=0; issue ADD r3 (wb_en=1), next cycle src1=r3 -> hazard=1 for 2 cycles, 2 bubbles inserted, stall_count=2, hazard=0 on the third cycle.
- **Load-use, forwarding on:** forward_en=1; issue LDR r4 (mem_read=1), next cycle src2=r4 with two_src=1 -> hazard=1 for exactly 1 cycle. Same sequence with two_src=0 and src1≠r4 -> hazard=0.
- **Simultaneous inc/dec:** issue to r7 while MEM retires r7 -> busy count stays 1 and busy_mask[7]=1. Back-to-back writes to r7 -> count reaches 2, then returns to 0 after 2 further idle cycles.
- **Freeze:** freeze=1 for 3 cycles with a load in EXE and a dependent in ID -> slots and counts unchanged, hazard held at 1, stall_count unchanged. Release -> the load advances.
- **Flush:** flush=1 with issue_valid=1, issue_wb_en=1, dest=r9 -> EXE becomes a bubble, busy_mask[9]=0. Saturation check: force stall_count near max, verify it holds at 0xFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared register-index sizing and shadow-slot record
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int NREGS     = 16;
    localparam int REG_IDX_W = $clog2(NREGS);

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_read;
        logic [REG_IDX_W-1:0] dest;
    } slot_t;

    localparam slot_t BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/reg_busy_counter.sv
// ============================================================================
// reg_busy_counter : 2-bit pending-write counter for one register (0..2)
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module reg_busy_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] busy
);

    logic [1:0] busy_q;
    logic [1:0] busy_d;

    // Simultaneous inc and dec cancel; otherwise clamp to the legal 0..2 range.
    always_comb begin
        busy_d = busy_q;
        if (inc && !dec && busy_q != 2'd2) begin
            busy_d = busy_q + 2'd1;
        end else if (dec && !inc && busy_q != 2'd0) begin
            busy_d = busy_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 2'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(inc && !dec && busy_q == 2'd2));

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
        !(dec && !inc && busy_q == 2'd0));

endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : EXE/MEM destination tracking, per-register busy counts and
//                  ID-stage stall generation (forwarding / non-forwarding)
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic                 issue_wb_en,
    input  logic                 issue_mem_read,
    input  logic [REG_IDX_W-1:0] issue_dest,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 two_src,
    input  logic                 forward_en,
    input  logic                 freeze,
    input  logic                 flush,
    output logic                 hazard,
    output logic [REG_IDX_W-1:0] exe_dest,
    output logic [REG_IDX_W-1:0] mem_dest,
    output logic                 exe_wb_en,
    output logic                 mem_wb_en,
    output logic                 exe_mem_read,
    output logic [NREGS-1:0]     busy_mask,
    output logic [CNT_W-1:0]     stall_count
);

    slot_t            exe_q;
    slot_t            exe_d;
    slot_t            mem_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    logic             w_haz_nofwd;
    logic             w_haz_fwd;
    logic             w_accept;
    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_dec;
    logic [1:0]       w_busy [NREGS];

    assign w_haz_nofwd = busy_mask[src1] | (two_src & busy_mask[src2]);

    // With forwarding only a load still in EXE cannot supply its result in time.
    assign w_haz_fwd   = exe_q.valid & exe_q.mem_read & exe_q.wb_en &
                         ((src1 == exe_q.dest) | (two_src & (src2 == exe_q.dest)));

    assign hazard   = issue_valid & (forward_en ? w_haz_fwd : w_haz_nofwd);
    assign w_accept = issue_valid & ~hazard & ~flush;

    always_comb begin
        exe_d = BUBBLE;
        if (w_accept) begin
            exe_d.valid    = 1'b1;
            exe_d.wb_en    = issue_wb_en;
            exe_d.mem_read = issue_mem_read;
            exe_d.dest     = issue_dest;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (hazard && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q   <= BUBBLE;
            mem_q   <= BUBBLE;
            stall_q <= '0;
        end else if (!freeze) begin
            exe_q   <= exe_d;
            mem_q   <= exe_q;
            stall_q <= stall_d;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_busy
        localparam logic [REG_IDX_W-1:0] c_IDX = REG_IDX_W'(i);

        assign w_inc[i] = ~freeze & w_accept & issue_wb_en & (issue_dest == c_IDX);
        assign w_dec[i] = ~freeze & mem_q.valid & mem_q.wb_en & (mem_q.dest == c_IDX);

        reg_busy_counter u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (w_inc[i]),
            .dec  (w_dec[i]),
            .busy (w_busy[i])
        );

        assign busy_mask[i] = (w_busy[i] != 2'd0);
    end

    assign exe_dest     = exe_q.dest;
    assign mem_dest     = mem_q.dest;
    assign exe_wb_en    = exe_q.valid & exe_q.wb_en;
    assign mem_wb_en    = mem_q.valid & mem_q.wb_en;
    assign exe_mem_read = exe_q.mem_read;
    assign stall_count  = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// tb_reg_scoreboard : directed + random check of reg_scoreboard against an
//                     in-flight-instruction reference model
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid, issue_wb_en, issue_mem_read;
    logic [3:0]  issue_dest, src1, src2;
    logic        two_src, forward_en, freeze, flush;
    logic        hazard;
    logic [3:0]  exe_dest, mem_dest;
    logic        exe_wb_en, mem_wb_en, exe_mem_read;
    logic [15:0] busy_mask;
    logic [15:0] stall_count;

    logic        s_hazard;
    logic [3:0]  s_exe_dest, s_mem_dest;
    logic        s_exe_wb_en, s_mem_wb_en, s_exe_mem_read;
    logic [15:0] s_busy_mask;
    logic [3:0]  s_stall_count;

    reg_scoreboard #(.NREGS(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_mem_read(issue_mem_read), .issue_dest(issue_dest), .src1(src1), .src2(src2),
        .two_src(two_src), .forward_en(forward_en), .freeze(freeze), .flush(flush),
        .hazard(hazard), .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en),
        .mem_wb_en(mem_wb_en), .exe_mem_read(exe_mem_read), .busy_mask(busy_mask),
        .stall_count(stall_count)
    );

    // Narrow stall counter so saturation is reachable in a short run.
    reg_scoreboard #(.NREGS(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_mem_read(issue_mem_read), .issue_dest(issue_dest), .src1(src1), .src2(src2),
        .two_src(two_src), .forward_en(forward_en), .freeze(freeze), .flush(flush),
        .hazard(s_hazard), .exe_dest(s_exe_dest), .mem_dest(s_mem_dest),
        .exe_wb_en(s_exe_wb_en), .mem_wb_en(s_mem_wb_en), .exe_mem_read(s_exe_mem_read),
        .busy_mask(s_busy_mask), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the two in-flight instructions, oldest last.
    typedef struct {
        bit v;
        bit wb;
        bit ld;
        int d;
    } ent_t;

    ent_t m_exe, m_mem;
    int   m_stall, m_stall_s;
    bit   obs_haz;

    function automatic int pending(input int r);
        int n = 0;
        if (m_exe.v && m_exe.wb && m_exe.d == r) n++;
        if (m_mem.v && m_mem.wb && m_mem.d == r) n++;
        return n;
    endfunction

    function automatic bit model_hazard();
        if (!issue_valid) return 1'b0;
        if (forward_en)
            return m_exe.v && m_exe.ld && m_exe.wb &&
                   (int'(src1) == m_exe.d || (two_src && int'(src2) == m_exe.d));
        return pending(int'(src1)) > 0 || (two_src && pending(int'(src2)) > 0);
    endfunction

    task automatic model_reset();
        m_exe     = '{v: 1'b0, wb: 1'b0, ld: 1'b0, d: 0};
        m_mem     = m_exe;
        m_stall   = 0;
        m_stall_s = 0;
    endtask

    task automatic drive(input bit v, input bit wb, input bit ld, input int d,
                         input int s1, input int s2, input bit tw, input bit fw,
                         input bit fz, input bit fl);
        issue_valid    = v;
        issue_wb_en    = wb;
        issue_mem_read = ld;
        issue_dest     = 4'(d);
        src1           = 4'(s1);
        src2           = 4'(s2);
        two_src        = tw;
        forward_en     = fw;
        freeze         = fz;
        flush          = fl;
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic tick();
        bit          exp_h;
        logic [15:0] exp_mask;
        #1;
        exp_h = model_hazard();
        for (int i = 0; i < 16; i++) exp_mask[i] = (pending(i) > 0);
        check_eq("hazard", hazard, exp_h);
        check_eq("busy_mask", busy_mask, exp_mask);
        check_eq("exe_dest", exe_dest, m_exe.d);
        check_eq("mem_dest", mem_dest, m_mem.d);
        check_eq("exe_wb_en", exe_wb_en, m_exe.v && m_exe.wb);
        check_eq("mem_wb_en", mem_wb_en, m_mem.v && m_mem.wb);
        check_eq("exe_mem_read", exe_mem_read, m_exe.v && m_exe.ld);
        check_eq("stall_count", stall_count, m_stall);
        check_eq("stall_count_small", s_stall_count, m_stall_s);
        obs_haz = hazard;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (!freeze) begin
            m_mem = m_exe;
            if (issue_valid && !exp_h && !flush)
                m_exe = '{v: 1'b1, wb: issue_wb_en, ld: issue_mem_read, d: int'(issue_dest)};
            else
                m_exe = '{v: 1'b0, wb: 1'b0, ld: 1'b0, d: 0};
            if (exp_h) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall_s < 15) m_stall_s++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit fw);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, fw, 0, 0);
            tick();
        end
    endtask

    bit [2:0] hz;
    int       s0;

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b1;

        // Reset mid-operation with r3 in EXE and r5 in MEM.
        drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0); tick();
        check_eq("pre_reset_mask", busy_mask, 16'h0028);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        rst = 1'b1;
        check_eq("reset_mask", busy_mask, 0);
        check_eq("reset_slots", {exe_wb_en, mem_wb_en, exe_dest, mem_dest}, 0);

        // Non-forwarding RAW: two bubbles, then the consumer issues.
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0); tick();
        s0 = int'(stall_count);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 3, 0, 0, 0, 0, 0); tick();
            hz[2-k] = obs_haz;
        end
        check_eq("raw_haz_seq", hz, 3'b110);
        check_eq("raw_stalls", int'(stall_count) - s0, 2);

        // Load-use with forwarding: exactly one bubble.
        idle(2, 1);
        drive(1, 1, 1, 4, 0, 0, 0, 1, 0, 0); tick();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
            hz[1-k] = obs_haz;
        end
        check_eq("loaduse_seq", hz[1:0], 2'b10);
        idle(2, 1);
        drive(1, 1, 1, 4, 0, 0, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 5, 4, 0, 1, 0, 0); tick();
        check_eq("loaduse_onesrc", obs_haz, 0);

        // Simultaneous inc/dec on r7, then back-to-back writes.
        idle(2, 0);
        drive(1, 1, 0, 7, 0, 0, 0, 0, 0, 0); tick();
        idle(1, 0);
        drive(1, 1, 0, 7, 0, 0, 0, 0, 0, 0); tick();
        check_eq("incdec_r7", busy_mask[7], 1);
        drive(1, 1, 0, 7, 0, 0, 0, 0, 0, 0); tick();
        idle(1, 0);
        check_eq("r7_after_1_idle", busy_mask[7], 1);
        idle(1, 0);
        check_eq("r7_after_2_idle", busy_mask[7], 0);

        // Freeze with a load in EXE and a dependent in ID.
        idle(2, 1);
        drive(1, 1, 1, 2, 0, 0, 0, 1, 0, 0); tick();
        s0 = int'(stall_count);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 2, 0, 0, 1, 1, 0); tick();
            check_eq("freeze_haz", obs_haz, 1);
        end
        check_eq("freeze_exe", {exe_dest, exe_mem_read, busy_mask[2]}, {4'd2, 1'b1, 1'b1});
        check_eq("freeze_stall", int'(stall_count) - s0, 0);
        drive(1, 0, 0, 0, 2, 0, 0, 1, 0, 0); tick();
        check_eq("unfreeze_haz", obs_haz, 1);
        check_eq("unfreeze_advance", {mem_dest, mem_wb_en, exe_wb_en}, {4'd2, 1'b1, 1'b0});

        // Flush drops the ID instruction.
        drive(1, 1, 0, 9, 0, 0, 0, 1, 0, 1); tick();
        check_eq("flush_exe", exe_wb_en, 0);
        check_eq("flush_mask9", busy_mask[9], 0);

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            tick();
        end
        rst = 1'b1;

        // Sustained self-dependent stream drives the narrow counter to saturation.
        for (int n = 0; n < 40; n++) begin
            drive(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
            tick();
        end
        check_eq("stall_small_sat", s_stall_count, 4'hF);
        idle(3, 0);
        check_eq("stall_small_hold", s_stall_count, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
